// File: rtl/tbu_pkg.sv
// rtl/tbu_pkg.sv - shared types and helpers for the traceback window decoder
//
// Contents:
//   tbu_state_t  - window controller states (fill, trace, emit)
//   START_ZERO / START_BEST - START_MODE encodings
//   ptr_width()  - clog2-based width for pointers and counters (minimum 1 bit)
package tbu_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRACE = 2'd1,
        ST_EMIT  = 2'd2
    } tbu_state_t;

    localparam int START_ZERO = 0;
    localparam int START_BEST = 1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tbu_dec_mem.sv
// rtl/tbu_dec_mem.sv - survivor decision buffer, one sync write port, one async read port
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - decision vector to store
//   raddr  - read address
//   rdata  - decision vector at raddr (combinational)
module tbu_dec_mem #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // No reset: stale contents are never read before being rewritten,
    // because a fresh window always refills every entry it traces through.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tbu_window.sv
// rtl/tbu_window.sv - windowed Viterbi traceback unit with overlap
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   dec_valid/dec_ready   - decision vector handshake (ready only while filling)
//   dec_vec               - one survivor decision bit per trellis state
//   best_state            - best-metric state, latched with the window's last vector
//   out_valid/out_ready   - decoded bit handshake
//   out_bit               - decoded bit, oldest first
//   out_last              - marks the final bit of each window
module tbu_window
    import tbu_pkg::*;
#(
    parameter int K          = 4,
    parameter int TB_LEN     = 16,
    parameter int DEC_LEN    = 16,
    parameter int START_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [(1<<(K-1))-1:0] dec_vec,
    input  logic [K-2:0]          best_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  out_last
);

    localparam int NS    = 1 << (K - 1);
    localparam int SW    = K - 1;
    localparam int FRAME = TB_LEN + DEC_LEN;
    localparam int PW    = ptr_width(FRAME);
    localparam int CW    = ptr_width(FRAME + 1);
    localparam int IW    = ptr_width(DEC_LEN);

    tbu_state_t        state, state_nxt;
    logic [PW-1:0]     wptr, rptr, step;
    logic [CW-1:0]     count;
    logic [SW-1:0]     trace_s;
    logic [NS-1:0]     rd_vec;
    logic [DEC_LEN-1:0] obuf;
    logic [IW-1:0]     oidx, oidx_nx, wr_idx;
    logic              accept, fill_done, trace_done, emit_done;

    tbu_dec_mem #(
        .DEPTH (FRAME),
        .WIDTH (NS),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr),
        .wdata (dec_vec),
        .raddr (rptr),
        .rdata (rd_vec)
    );

    assign dec_ready  = (state == ST_FILL);
    assign accept     = dec_valid && dec_ready;
    // count reaches FRAME for the first window and after DEC_LEN new vectors
    // for later ones, since the overlap leaves count at TB_LEN.
    assign fill_done  = accept && (count == CW'(FRAME - 1));
    assign trace_done = (step == PW'(FRAME - 1));
    assign emit_done  = out_valid && out_ready && (oidx == IW'(DEC_LEN - 1));
    // Step TB_LEN+j lands at index DEC_LEN-1-j, which is FRAME-1-step.
    assign wr_idx     = IW'(PW'(FRAME - 1) - step);
    assign oidx_nx    = oidx + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:  if (fill_done)  state_nxt = ST_TRACE;
            ST_TRACE: if (trace_done) state_nxt = ST_EMIT;
            ST_EMIT:  if (emit_done)  state_nxt = ST_FILL;
            default:  state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            step      <= '0;
            count     <= '0;
            trace_s   <= '0;
            obuf      <= '0;
            oidx      <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        wptr  <= (wptr == PW'(FRAME - 1)) ? '0 : wptr + PW'(1);
                        count <= count + CW'(1);
                        if (fill_done) begin
                            // Trace starts at the vector just written.
                            rptr    <= wptr;
                            step    <= '0;
                            trace_s <= (START_MODE == START_BEST) ? best_state : '0;
                        end
                    end
                end
                ST_TRACE: begin
                    if (step >= PW'(TB_LEN)) begin
                        obuf[wr_idx] <= trace_s[SW-1];
                    end
                    trace_s <= {trace_s[SW-2:0], rd_vec[trace_s]};
                    rptr    <= (rptr == '0) ? PW'(FRAME - 1) : rptr - PW'(1);
                    step    <= step + PW'(1);
                    oidx    <= '0;
                end
                ST_EMIT: begin
                    if (!out_valid) begin
                        // First EMIT cycle presents the oldest bit.
                        out_valid <= 1'b1;
                        out_bit   <= obuf[oidx];
                        out_last  <= (oidx == IW'(DEC_LEN - 1));
                    end else if (out_ready) begin
                        if (emit_done) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            count     <= CW'(TB_LEN);
                        end else begin
                            oidx     <= oidx_nx;
                            out_bit  <= obuf[oidx_nx];
                            out_last <= (oidx_nx == IW'(DEC_LEN - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tbu_window.md
TBU_WINDOW -- requirements
Module: tbu_window

Interface
REQ-001 Parameter K, default 4: constraint length, 3..7; NS = 2^(K-1) trellis states, SW = K-1 state bits.
REQ-002 Parameter TB_LEN, default 16: traceback depth; these steps are discarded, >= 1.
REQ-003 Parameter DEC_LEN, default 16: bits decoded per window, >= 1; FRAME = TB_LEN+DEC_LEN.
REQ-004 Parameter START_MODE, default 0: 0 = trace from state 0, 1 = trace from best_state.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 dec_valid  in  1  decision vector valid.
REQ-008 dec_ready  out  1  block accepts a vector; accept = dec_valid && dec_ready.
REQ-009 dec_vec  in  NS  survivor decision bit per state, one ACS step.
REQ-010 best_state  in  SW  ACS best-metric state, sampled on the accepting edge.
REQ-011 out_valid  out  1  out_bit valid.
REQ-012 out_ready  in  1  consumer accepts; transfer = out_valid && out_ready.
REQ-013 out_bit  out  1  decoded bit, chronological order.
REQ-014 out_last  out  1  high with last bit (index DEC_LEN-1) of each window.

Function
REQ-015 FSM states FILL, TRACE, EMIT; dec_ready = 1 only in FILL.
REQ-016 FILL: each accept writes dec_vec to circular buffer (depth FRAME) at wptr; wptr wraps FRAME-1 -> 0; fill count increments.
REQ-017 FILL -> TRACE on the accept making count = FRAME (first window) or count = DEC_LEN new vectors (later windows); best_state latched on that edge.
REQ-018 TRACE: one step per cycle, FRAME cycles, reading newest to oldest (rptr starts wptr-1, decrements with wrap).
REQ-019 Start state s = 0 (START_MODE 0) or latched best_state (START_MODE 1).
REQ-020 Step k: decoded bit = s[SW-1]; next s = {s[SW-2:0], mem[rptr][s]}.
REQ-021 Steps k < TB_LEN discarded; step k = TB_LEN+j stores bit at output index DEC_LEN-1-j.
REQ-022 TRACE -> EMIT after step FRAME-1; out_valid asserts the following cycle with index 0 (oldest).
REQ-023 EMIT: out_bit/out_last registered, held stable while out_valid && !out_ready; index advances only on transfer.
REQ-024 Transfer of index DEC_LEN-1 -> FILL next cycle, out_valid low; newest TB_LEN vectors retained as overlap, count = TB_LEN.
REQ-025 dec_valid ignored outside FILL; no vector lost or written while dec_ready = 0.
REQ-026 Latency: last accept to first out_valid = FRAME+1 cycles.

Reset
REQ-027 rst high: state FILL, wptr = 0, count = 0, dec_ready = 1, out_valid = 0, out_bit = 0, out_last = 0, latched start = 0, immediately and asynchronously.
REQ-028 rst in TRACE or EMIT aborts the window; pending bits lost; buffer contents need not clear; next window requires FRAME fresh vectors.

Structure
REQ-029 Package tbu_pkg: FSM state enum, clog2-based pointer/count width function, START_MODE constants.
REQ-030 Sub-module tbu_dec_mem: FRAME x NS register array, one synchronous write port, one combinational read port (depth, width parameterised).

Verification
REQ-031 Reset: rst pulse mid-FILL -> dec_ready=1, out_valid=0, out_bit=0 same cycle; counts restart.
REQ-032 K=4, TB=DEC=16, START_MODE 0, 32 vectors 0x00 -> 16 zeros after 33 cycles, out_last on 16th; 16 more 0x00 -> 16 zeros (overlap works).
REQ-033 Same config, 32 vectors 0xFF -> states 0,1,3,7,7,... -> 16 ones emitted.
REQ-034 K=4, TB=2, DEC=4, START_MODE 1, best_state=5, six vectors 0x00 -> trace 5,2,4,0,0,0 -> emitted 0,0,0,1, out_last with the 1.
REQ-035 Backpressure: out_ready low 5 cycles mid-EMIT -> out_bit/out_last stable, dec_ready=0, dec_valid pulses ignored, no bit dropped/duplicated.
REQ-036 rst asserted TRACE step 10 -> FILL, out_valid never asserts; 32 fresh 0xFF vectors -> 16 ones.
